cc_alu_arbiter: RTL and testbench

//   Two-requester round-robin arbiter and sequencer in front of the combinational CC_ALU.

---
 rtl/cc_alu_arbiter.sv | 153 +++++++++++++++
 tb/tb_cc_alu_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cc_alu_arbiter
// Brief    : Two-requester round-robin arbiter/sequencer in front of CC_ALU.
//            Optional icc register enabled by defining CC_ALUARB_ICC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cc_alu_arbiter #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                                 CC_ALUARB_CLOCK_50,
    input  logic                                 CC_ALUARB_RESET_InHigh,
    input  logic [1:0]                           CC_ALUARB_reqValid_InBUS,
    output logic [1:0]                           CC_ALUARB_reqReady_OutBUS,
    input  logic [2*DATAWIDTH_BUS-1:0]           CC_ALUARB_dataA_InBUS,
    input  logic [2*DATAWIDTH_BUS-1:0]           CC_ALUARB_dataB_InBUS,
    input  logic [2*DATAWIDTH_ALU_SELECTION-1:0] CC_ALUARB_sel_InBUS,
    output logic [1:0]                           CC_ALUARB_rspValid_OutBUS,
    input  logic [1:0]                           CC_ALUARB_rspReady_InBUS,
    output logic [DATAWIDTH_BUS-1:0]             CC_ALUARB_rspData_OutBUS,
    output logic [3:0]                           CC_ALUARB_rspFlags_OutBUS,
    output logic [3:0]                           CC_ALUARB_icc_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             CC_ALUARB_aluA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]             CC_ALUARB_aluB_OutBUS,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]   CC_ALUARB_aluSel_OutBUS,
    input  logic [DATAWIDTH_BUS-1:0]             CC_ALUARB_aluData_InBUS,
    input  logic [3:0]                           CC_ALUARB_aluFlagsLow_InBUS
);

    localparam int DW = DATAWIDTH_BUS;
    localparam int SW = DATAWIDTH_ALU_SELECTION;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_grant;
    logic            r_lastGrant;
    logic            w_grantIdx;
    logic            w_accept;
    logic [1:0]      w_reqReady;
    logic [1:0]      w_rspValid;
    logic [DW-1:0]   r_aluA;
    logic [DW-1:0]   r_aluB;
    logic [SW-1:0]   r_aluSel;
    logic [DW-1:0]   r_rspData;
    logic [3:0]      r_rspFlags;

    // Round-robin: on contention the requester not served last wins.
    always_comb begin
        w_grantIdx = CC_ALUARB_reqValid_InBUS[1];
        if (&CC_ALUARB_reqValid_InBUS) begin
            w_grantIdx = ~r_lastGrant;
        end
    end

    always_ff @(posedge CC_ALUARB_CLOCK_50) begin
        if (CC_ALUARB_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_reqReady  = 2'b00;
        w_rspValid  = 2'b00;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|CC_ALUARB_reqValid_InBUS) begin
                    w_reqReady[w_grantIdx] = 1'b1;
                    w_accept               = 1'b1;
                    w_stateNext            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_stateNext = ST_RESP;
            end
            ST_RESP: begin
                w_rspValid[r_grant] = 1'b1;
                if (CC_ALUARB_rspReady_InBUS[r_grant]) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CC_ALUARB_CLOCK_50) begin
        if (CC_ALUARB_RESET_InHigh) begin
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluSel    <= '0;
            r_rspData   <= '0;
            r_rspFlags  <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_grant     <= w_grantIdx;
                r_lastGrant <= w_grantIdx;
                r_aluA      <= w_grantIdx ? CC_ALUARB_dataA_InBUS[2*DW-1:DW]
                                          : CC_ALUARB_dataA_InBUS[DW-1:0];
                r_aluB      <= w_grantIdx ? CC_ALUARB_dataB_InBUS[2*DW-1:DW]
                                          : CC_ALUARB_dataB_InBUS[DW-1:0];
                r_aluSel    <= w_grantIdx ? CC_ALUARB_sel_InBUS[2*SW-1:SW]
                                          : CC_ALUARB_sel_InBUS[SW-1:0];
            end
            // ALU flags arrive active-low; the response carries them active-high.
            if (r_state == ST_ISSUE) begin
                r_rspData  <= CC_ALUARB_aluData_InBUS;
                r_rspFlags <= ~CC_ALUARB_aluFlagsLow_InBUS;
            end
        end
    end

`ifdef CC_ALUARB_ICC_EN
    // Only ANDCC/ORCC/NORCC/ADDCC (opcodes 0..3) update the condition codes.
    localparam logic [SW-1:0] C_ICC_OP_LIMIT = SW'(4);
    logic [3:0] r_icc;

    always_ff @(posedge CC_ALUARB_CLOCK_50) begin
        if (CC_ALUARB_RESET_InHigh) begin
            r_icc <= 4'b0000;
        end else if ((r_state == ST_ISSUE) && (r_aluSel < C_ICC_OP_LIMIT)) begin
            r_icc <= ~CC_ALUARB_aluFlagsLow_InBUS;
        end
    end

    assign CC_ALUARB_icc_OutBUS = r_icc;
`else
    assign CC_ALUARB_icc_OutBUS = 4'b0000;
`endif

    assign CC_ALUARB_reqReady_OutBUS = w_reqReady;
    assign CC_ALUARB_rspValid_OutBUS = w_rspValid;
    assign CC_ALUARB_rspData_OutBUS  = r_rspData;
    assign CC_ALUARB_rspFlags_OutBUS = r_rspFlags;
    assign CC_ALUARB_aluA_OutBUS     = r_aluA;
    assign CC_ALUARB_aluB_OutBUS     = r_aluB;
    assign CC_ALUARB_aluSel_OutBUS   = r_aluSel;

endmodule
`default_nettype wire

// File: tb/tb_cc_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_alu_arbiter
// Brief    : Self-checking bench for cc_alu_arbiter with a behavioural CC_ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cc_alu_arbiter;

`ifdef CC_ALUARB_ICC_EN
    localparam bit ICC_ON = 1'b1;
`else
    localparam bit ICC_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  reqValid;
    logic [1:0]  reqReady;
    logic [63:0] dataA;
    logic [63:0] dataB;
    logic [7:0]  sel;
    logic [1:0]  rspValid;
    logic [1:0]  rspReady;
    logic [31:0] rspData;
    logic [3:0]  rspFlags;
    logic [3:0]  icc;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  aluSel;
    logic [31:0] aluData;
    logic [3:0]  aluFlagsLow;

    int errors = 0;
    int checks = 0;

    cc_alu_arbiter #(.DATAWIDTH_BUS(32), .DATAWIDTH_ALU_SELECTION(4)) dut (
        .CC_ALUARB_CLOCK_50          (clk),
        .CC_ALUARB_RESET_InHigh      (rst),
        .CC_ALUARB_reqValid_InBUS    (reqValid),
        .CC_ALUARB_reqReady_OutBUS   (reqReady),
        .CC_ALUARB_dataA_InBUS       (dataA),
        .CC_ALUARB_dataB_InBUS       (dataB),
        .CC_ALUARB_sel_InBUS         (sel),
        .CC_ALUARB_rspValid_OutBUS   (rspValid),
        .CC_ALUARB_rspReady_InBUS    (rspReady),
        .CC_ALUARB_rspData_OutBUS    (rspData),
        .CC_ALUARB_rspFlags_OutBUS   (rspFlags),
        .CC_ALUARB_icc_OutBUS        (icc),
        .CC_ALUARB_aluA_OutBUS       (aluA),
        .CC_ALUARB_aluB_OutBUS       (aluB),
        .CC_ALUARB_aluSel_OutBUS     (aluSel),
        .CC_ALUARB_aluData_InBUS     (aluData),
        .CC_ALUARB_aluFlagsLow_InBUS (aluFlagsLow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CC_ALU: returns {N,Z,V,C active-high, result}.
    function automatic logic [35:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] s);
        logic [32:0] sum;
        logic [31:0] res;
        logic        v;
        logic        c;
        sum = {1'b0, a} + {1'b0, b};
        v   = 1'b0;
        c   = 1'b0;
        case (s)
            4'd0:       res = a & b;
            4'd1:       res = a | b;
            4'd2:       res = ~(a | b);
            4'd3, 4'd8: begin
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            default:    res = a ^ b;
        endcase
        return {res[31], (res == 32'd0), v, c, res};
    endfunction

    always_comb begin
        logic [35:0] r;
        r           = aluRef(aluA, aluB, aluSel);
        aluData     = r[31:0];
        aluFlagsLow = ~r[35:32];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        reqValid = 2'b00;
        rspReady = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic setReq(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s);
        dataA[r*32 +: 32] = a;
        dataB[r*32 +: 32] = b;
        sel[r*4 +: 4]     = s;
    endtask

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        logic [31:0] d;
        logic [3:0]  f;
        logic [3:0]  iccEn;
    } vec_t;

    vec_t vecs[6];

    // Random-phase reference model state (transaction timeline, not FSM states).
    bit          pend[2];
    logic [31:0] pA[2];
    logic [31:0] pB[2];
    logic [3:0]  pS[2];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [35:0] ref36;
        bit          outst;
        int          owner;
        int          accCyc;
        bit          lastG;
        int          w;
        logic [1:0]  expRdy;
        logic [1:0]  expRsp;
        logic [31:0] expD;
        logic [31:0] expA;
        logic [3:0]  expF;
        logic [3:0]  expS;
        logic [3:0]  mIcc;
        bit          got;

        vecs[0] = '{0, 32'h5,        32'h3,        4'd3, 32'h8,        4'b0000, 4'b0000};
        vecs[1] = '{1, 32'hFFFFFFFF, 32'h1,        4'd3, 32'h0,        4'b0101, 4'b0101};
        vecs[2] = '{0, 32'h7FFFFFFF, 32'h1,        4'd8, 32'h80000000, 4'b1010, 4'b0101};
        vecs[3] = '{1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd0, 32'hF000F000, 4'b1000, 4'b1000};
        vecs[4] = '{0, 32'h0,        32'h0,        4'd1, 32'h0,        4'b0100, 4'b0100};
        vecs[5] = '{1, 32'hFFFFFFFF, 32'h0,        4'd5, 32'hFFFFFFFF, 4'b1000, 4'b0100};

        dataA = '0; dataB = '0; sel = '0;
        doReset();
        check("reset_reqReady", reqReady, 2'b00);
        check("reset_rspValid", rspValid, 2'b00);
        check("reset_rspData", rspData, 0);
        check("reset_rspFlags", rspFlags, 0);
        check("reset_icc", icc, 0);
        check("reset_aluA", aluA, 0);
        check("reset_aluB", aluB, 0);
        check("reset_aluSel", aluSel, 0);

        // Table-driven single operations.
        foreach (vecs[k]) begin
            setReq(vecs[k].r, vecs[k].a, vecs[k].b, vecs[k].s);
            reqValid = 2'b01 << vecs[k].r;
            rspReady = 2'b00;
            #1;
            check("vec_reqReady", reqReady, 2'b01 << vecs[k].r);
            tick();
            reqValid = 2'b00;
            #1;
            check("vec_issue_reqReady", reqReady, 2'b00);
            check("vec_issue_rspValid", rspValid, 2'b00);
            check("vec_aluA", aluA, vecs[k].a);
            check("vec_aluB", aluB, vecs[k].b);
            check("vec_aluSel", aluSel, vecs[k].s);
            tick();
            check("vec_rspValid", rspValid, 2'b01 << vecs[k].r);
            check("vec_rspData", rspData, vecs[k].d);
            check("vec_rspFlags", rspFlags, vecs[k].f);
            check("vec_icc", icc, ICC_ON ? vecs[k].iccEn : 4'b0000);
            rspReady = 2'b11;
            tick();
            rspReady = 2'b00;
            #1;
            check("vec_done_rspValid", rspValid, 2'b00);
        end

        // Fairness with both requesters held valid from reset.
        doReset();
        setReq(0, 32'h10, 32'h1, 4'd3);
        setReq(1, 32'h20, 32'h2, 4'd3);
        reqValid = 2'b11;
        rspReady = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                check("fair_not_both", reqReady == 2'b11, 1'b0);
                if (reqReady != 2'b00) begin
                    check("fair_grant", reqReady, (k % 2 == 0) ? 2'b01 : 2'b10);
                    got = 1'b1;
                end
                tick();
            end
            if (!got) check("fair_timeout", 1'b0, 1'b1);
        end
        reqValid = 2'b00;
        rspReady = 2'b00;
        for (int t = 0; t < 4; t++) tick();

        // Stalled response: data held, new requests blocked, foreign rspReady ignored.
        doReset();
        setReq(0, 32'hFFFFFFFF, 32'h1, 4'd3);
        reqValid = 2'b01;
        #1;
        check("stall_accept", reqReady, 2'b01);
        tick();
        setReq(1, 32'h7FFFFFFF, 32'h1, 4'd8);
        reqValid = 2'b10;
        #1;
        check("stall_issue_reqReady", reqReady, 2'b00);
        tick();
        for (int t = 0; t < 3; t++) begin
            rspReady = (t == 1) ? 2'b10 : 2'b00;
            #1;
            check("stall_rspValid", rspValid, 2'b01);
            check("stall_rspData", rspData, 32'h0);
            check("stall_rspFlags", rspFlags, 4'b0101);
            check("stall_reqReady", reqReady, 2'b00);
            tick();
        end
        rspReady = 2'b01;
        tick();
        rspReady = 2'b00;
        #1;
        check("stall_next_grant", reqReady, 2'b10);
        tick();
        reqValid = 2'b00;
        tick();
        check("add_ovf_data", rspData, 32'h80000000);
        check("add_ovf_flags", rspFlags, 4'b1010);
        check("add_ovf_icc", icc, ICC_ON ? 4'b0101 : 4'b0000);
        rspReady = 2'b10;
        tick();
        rspReady = 2'b00;

        // Reset during ISSUE discards the operation and restores R0 priority.
        setReq(0, 32'h2, 32'h2, 4'd3);
        reqValid = 2'b01;
        #1;
        check("rst_accept", reqReady, 2'b01);
        tick();
        reqValid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_rspValid", rspValid, 2'b00);
        check("rst_icc", icc, 4'b0000);
        check("rst_rspData", rspData, 32'h0);
        reqValid = 2'b11;
        #1;
        check("rst_first_grant", reqReady, 2'b01);

        // Randomised traffic against the transaction-level model.
        doReset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        outst = 1'b0; owner = 0; accCyc = 0; lastG = 1'b1; mIcc = 4'b0000;
        expD = '0; expF = '0; expA = '0; expS = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pA[i] = $urandom;
                    pB[i] = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
                    pS[i] = 4'($urandom_range(0, 15));
                    setReq(i, pA[i], pB[i], pS[i]);
                end
            end
            reqValid = {pend[1], pend[0]};
            rspReady = 2'($urandom_range(0, 3));
            #1;
            expRdy = 2'b00;
            w = 0;
            if (!outst && (pend[0] || pend[1])) begin
                w      = (pend[0] && pend[1]) ? int'(!lastG) : int'(pend[1]);
                expRdy = 2'b01 << w;
            end
            expRsp = (outst && cyc >= accCyc + 2) ? (2'b01 << owner) : 2'b00;
            check("rnd_reqReady", reqReady, expRdy);
            check("rnd_rspValid", rspValid, expRsp);
            if (expRsp != 2'b00) begin
                check("rnd_rspData", rspData, expD);
                check("rnd_rspFlags", rspFlags, expF);
            end
            if (outst && cyc > accCyc) begin
                check("rnd_aluA", aluA, expA);
                check("rnd_aluSel", aluSel, expS);
            end
            check("rnd_icc", icc, mIcc);
            if (outst && cyc == accCyc + 1 && ICC_ON && expS < 4'd4) mIcc = expF;
            if (expRsp != 2'b00 && rspReady[owner]) outst = 1'b0;
            if (expRdy != 2'b00) begin
                ref36   = aluRef(pA[w], pB[w], pS[w]);
                expD    = ref36[31:0];
                expF    = ref36[35:32];
                expA    = pA[w];
                expS    = pS[w];
                outst   = 1'b1;
                owner   = w;
                accCyc  = cyc;
                lastG   = w[0];
                pend[w] = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
